// File: rtl/timing_pkg.sv
// -----------------------------------------------------------------------------
// timing_pkg
// Shared timing constants and helpers for everything clocked off the 100 MHz
// system clock.
//
// Contents:
//   BASIC_CLOCK_RATE : system clock frequency in Hz
//   CLOCK_WIDTH      : counter width that covers one second of system clocks
//   ONE_HZ_COUNT     : half-period count of a 1 Hz square wave
//   cfg_status_e     : outcome of a divisor write request
//   hz_to_div(f)     : divisor giving a level output of frequency f Hz
// -----------------------------------------------------------------------------
package timing_pkg;

  localparam int unsigned BASIC_CLOCK_RATE = 100_000_000;
  localparam int unsigned CLOCK_WIDTH      = 27;
  localparam int unsigned ONE_HZ_COUNT     = 50_000_000;

  // Classification of the configuration port in a given cycle.
  typedef enum logic [1:0] {
    CFG_IDLE   = 2'd0,
    CFG_ACCEPT = 2'd1,
    CFG_REJECT = 2'd2
  } cfg_status_e;

  // The level output toggles once per wrap, so its period is 2*D cycles.
  // A level frequency f therefore needs D = clock / (2*f).
  function automatic int unsigned hz_to_div(input int unsigned freq_hz);
    return BASIC_CLOCK_RATE / (2 * freq_hz);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
// One clock-enable channel: a modulo-D counter that emits a single-cycle tick
// on every wrap and toggles a 50%-duty level. A new divisor is staged as
// "pending" and only becomes active at a period boundary, so a running period
// is never shortened or stretched.
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : count enable (counter and level hold while low)
//   sync       : restart the channel at phase zero, applying any pending divisor
//   wr         : validated divisor write aimed at this channel
//   wr_div     : divisor carried by wr (already known to be non-zero)
//   tick       : registered one-cycle pulse at each wrap
//   level      : registered square wave, toggles at each wrap
//   pend       : a written divisor is waiting to be applied
//   cnt        : current counter value (for phase taps)
// -----------------------------------------------------------------------------
module tick_channel
  import timing_pkg::*;
#(
  parameter int                   CNT_WIDTH = CLOCK_WIDTH,
  parameter logic [CNT_WIDTH-1:0] RESET_DIV = CNT_WIDTH'(ONE_HZ_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sync,
  input  logic                 wr,
  input  logic [CNT_WIDTH-1:0] wr_div,
  output logic                 tick,
  output logic                 level,
  output logic                 pend,
  output logic [CNT_WIDTH-1:0] cnt
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] active_reg;
  logic [CNT_WIDTH-1:0] pending_reg;
  logic                 tick_reg;
  logic                 level_reg;
  logic                 pend_reg;
  logic                 at_wrap;

  // ">=" rather than "==": a divisor applied while the channel is stopped can
  // be smaller than the held count, and the channel must then wrap on its next
  // enabled cycle instead of running all the way round the counter.
  assign at_wrap = (cnt_reg >= (active_reg - ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      active_reg  <= RESET_DIV;
      pending_reg <= RESET_DIV;
      tick_reg    <= 1'b0;
      level_reg   <= 1'b0;
      pend_reg    <= 1'b0;
    end else begin
      if (sync) begin
        // pending_reg equals active_reg whenever nothing is pending, so the
        // copy is unconditional.
        cnt_reg    <= '0;
        level_reg  <= 1'b0;
        tick_reg   <= 1'b0;
        active_reg <= pending_reg;
        pend_reg   <= 1'b0;
      end else if (en) begin
        if (at_wrap) begin
          cnt_reg   <= '0;
          tick_reg  <= 1'b1;
          level_reg <= ~level_reg;
          if (pend_reg) begin
            active_reg <= pending_reg;
            pend_reg   <= 1'b0;
          end
        end else begin
          cnt_reg  <= cnt_reg + ONE;
          tick_reg <= 1'b0;
        end
      end else begin
        // A stopped channel has no period in flight, so a pending divisor can
        // take effect straight away.
        tick_reg <= 1'b0;
        if (pend_reg) begin
          active_reg <= pending_reg;
          pend_reg   <= 1'b0;
        end
      end

      // A write is sampled after the apply decision above: one arriving on a
      // wrap (or sync) edge waits for the next boundary, and the last write
      // before application wins.
      if (wr) begin
        pending_reg <= wr_div;
        pend_reg    <= 1'b1;
      end
    end
  end

  assign tick  = tick_reg;
  assign level = level_reg;
  assign pend  = pend_reg;
  assign cnt   = cnt_reg;

endmodule

// File: rtl/tick_generator_bank.sv
// -----------------------------------------------------------------------------
// tick_generator_bank
// Bank of NUM_CH runtime-programmable clock-enable generators used as the
// central timing source (VGA scan, seven-segment scan, blink, game timers).
// Each channel produces a one-cycle tick every D enabled cycles and a level
// that toggles on every wrap. Divisors are written through a small config port
// and applied glitch-free at the next period boundary.
//
// Ports:
//   clk      : 100 MHz system clock
//   rst_n    : asynchronous active-low reset
//   ch_en    : per-channel count enable
//   sync     : restart all channels at phase zero, applying pending divisors
//   cfg_we   : divisor write strobe
//   cfg_ch   : channel addressed by the write
//   cfg_div  : new divisor (1 .. 2^CNT_WIDTH-1)
//   cfg_err  : one-cycle pulse when a write is rejected
//   tick     : per-channel one-cycle tick
//   level    : per-channel square wave (period 2*D)
//   pend     : per-channel "divisor written but not yet applied"
//   iter_sig : bits [ITER_LSB +: ITER_WIDTH] of channel ITER_CH's counter
// -----------------------------------------------------------------------------
module tick_generator_bank
  import timing_pkg::*;
#(
  parameter int                          NUM_CH      = 4,
  parameter int                          CNT_WIDTH   = CLOCK_WIDTH,
  parameter logic [NUM_CH*CNT_WIDTH-1:0] DEFAULT_DIV = {NUM_CH{CNT_WIDTH'(ONE_HZ_COUNT)}},
  parameter int                          ITER_CH     = 0,
  parameter int                          ITER_LSB    = 13,
  parameter int                          ITER_WIDTH  = 2,
  parameter int                          CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic                  sync,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [CNT_WIDTH-1:0]  cfg_div,
  output logic                  cfg_err,
  output logic [NUM_CH-1:0]     tick,
  output logic [NUM_CH-1:0]     level,
  output logic [NUM_CH-1:0]     pend,
  output logic [ITER_WIDTH-1:0] iter_sig
);

  cfg_status_e                          cfg_status;
  logic                                 cfg_ch_ok;
  logic                                 cfg_div_ok;
  logic                                 cfg_err_reg;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]     cnt_all;
  logic                                 unused_cnt;

  // cfg_ch may be wider than needed to address NUM_CH channels, so an
  // out-of-range channel number is a real possibility.
  assign cfg_ch_ok  = (int'(cfg_ch) < NUM_CH);
  assign cfg_div_ok = (cfg_div != '0);

  always_comb begin
    cfg_status = CFG_IDLE;
    if (cfg_we) begin
      cfg_status = (cfg_ch_ok && cfg_div_ok) ? CFG_ACCEPT : CFG_REJECT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= (cfg_status == CFG_REJECT);
    end
  end

  assign cfg_err = cfg_err_reg;

  // One channel per generate iteration; sync is broadcast and the validated
  // write is steered to the addressed channel only.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr;

    assign wr = (cfg_status == CFG_ACCEPT) && (int'(cfg_ch) == gi);

    tick_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .RESET_DIV (DEFAULT_DIV[CNT_WIDTH*gi +: CNT_WIDTH])
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (ch_en[gi]),
      .sync   (sync),
      .wr     (wr),
      .wr_div (cfg_div),
      .tick   (tick[gi]),
      .level  (level[gi]),
      .pend   (pend[gi]),
      .cnt    (cnt_all[gi])
    );
  end

  // Phase tap for scan multiplexers; it is a slice of a register, so it is
  // as glitch-free as the other outputs.
  assign iter_sig = cnt_all[ITER_CH][ITER_LSB +: ITER_WIDTH];

  // Only one channel's counter is tapped; the rest are deliberately dropped.
  assign unused_cnt = ^cnt_all;

endmodule

// File: tb/tb_tick_generator_bank.sv
module tb_tick_generator_bank;

  localparam int NCH  = 2;
  localparam int CW   = 27;
  localparam int CHW  = 2;
  localparam int ICH  = 0;
  localparam int ILSB = 1;
  localparam int IW   = 2;
  localparam logic [NCH*CW-1:0] DEF = {27'd3, 27'd5};

  logic            clk     = 1'b0;
  logic            rst_n   = 1'b0;
  logic [NCH-1:0]  ch_en   = '0;
  logic            sync    = 1'b0;
  logic            cfg_we  = 1'b0;
  logic [CHW-1:0]  cfg_ch  = '0;
  logic [CW-1:0]   cfg_div = '0;
  logic            cfg_err;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  level;
  logic [NCH-1:0]  pend;
  logic [IW-1:0]   iter_sig;

  always #5 clk = ~clk;

  tick_generator_bank #(
    .NUM_CH      (NCH),
    .CNT_WIDTH   (CW),
    .DEFAULT_DIV (DEF),
    .ITER_CH     (ICH),
    .ITER_LSB    (ILSB),
    .ITER_WIDTH  (IW),
    .CH_W        (CHW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_en    (ch_en),
    .sync     (sync),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_err  (cfg_err),
    .tick     (tick),
    .level    (level),
    .pend     (pend),
    .iter_sig (iter_sig)
  );

  typedef struct {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] level;
    logic [NCH-1:0] pend;
    logic           err;
    logic [IW-1:0]  iter;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: each channel tracks how many enabled cycles of the
  // current period have elapsed, the period length in force, and a waiting
  // divisor that takes over at the next period boundary.
  int period  [NCH];
  int elapsed [NCH];
  int next_div[NCH];
  bit waiting [NCH];
  bit lvl     [NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      period[i]   = int'(DEF[CW*i +: CW]);
      next_div[i] = period[i];
      elapsed[i]  = 0;
      waiting[i]  = 1'b0;
      lvl[i]      = 1'b0;
    end
  endfunction

  // Model: advances on each clock edge using the inputs the DUT samples, and
  // queues the outputs the DUT must show during the following cycle.
  initial begin : model
    exp_t e;
    bit   bad;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      e.tick  = '0;
      e.level = '0;
      e.pend  = '0;
      e.err   = 1'b0;
      e.iter  = '0;
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
        exp_q.push_back(e);
      end else begin
        bad = cfg_we && ((int'(cfg_ch) >= NCH) || (cfg_div == 0));
        for (int i = 0; i < NCH; i++) begin
          if (sync) begin
            elapsed[i] = 0;
            lvl[i]     = 1'b0;
            period[i]  = next_div[i];
            waiting[i] = 1'b0;
          end else if (ch_en[i]) begin
            elapsed[i] = elapsed[i] + 1;
            if (elapsed[i] >= period[i]) begin
              elapsed[i] = 0;
              e.tick[i]  = 1'b1;
              lvl[i]     = ~lvl[i];
              if (waiting[i]) begin
                period[i]  = next_div[i];
                waiting[i] = 1'b0;
              end
            end
          end else if (waiting[i]) begin
            period[i]  = next_div[i];
            waiting[i] = 1'b0;
          end
          if (cfg_we && !bad && (int'(cfg_ch) == i)) begin
            next_div[i] = int'(cfg_div);
            waiting[i]  = 1'b1;
          end
          e.level[i] = lvl[i];
          e.pend[i]  = waiting[i];
        end
        e.err  = bad;
        e.iter = IW'(elapsed[ICH] / (1 << ILSB));
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares DUT outputs against the queued expectation mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mon_tick",  32'(tick),     32'(e.tick));
        check("mon_level", 32'(level),    32'(e.level));
        check("mon_pend",  32'(pend),     32'(e.pend));
        check("mon_err",   32'(cfg_err),  32'(e.err));
        check("mon_iter",  32'(iter_sig), 32'(e.iter));
      end
    end
  end

  // Default-divisor schedule counted in edges after reset release; with
  // with_write a divisor-2 write to ch0 is issued after edge 7.
  task automatic run_sched(input bit with_write);
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      if (with_write) begin
        check("sched_tick0", 32'(tick[0]), 32'(e == 5 || e == 10 || e == 12 || e == 14 || e == 16));
        check("sched_pend0", 32'(pend[0]), 32'(e == 8 || e == 9));
      end else begin
        check("sched_tick0", 32'(tick[0]), 32'(e % 5 == 0));
      end
      check("sched_tick1", 32'(tick[1]), 32'(e % 3 == 0));
      if (with_write && e == 7) begin
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 27'd2;
      end else begin
        cfg_we = 1'b0;
      end
    end
  endtask

  initial begin : stimulus
    ch_en = 2'b11;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_sched(1'b1);

    // Rejected writes: out-of-range channel, then zero divisor.
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 27'd4;
    @(posedge clk); #1;
    check("err_badch", 32'(cfg_err), 32'd1);
    cfg_ch = 2'd0; cfg_div = 27'd0;
    @(posedge clk); #1;
    check("err_zero", 32'(cfg_err), 32'd1);
    check("err_nopend", 32'(pend), 32'd0);
    cfg_we = 1'b0;
    @(posedge clk); #1;
    check("err_clear", 32'(cfg_err), 32'd0);

    // Pause channel 1, then let it resume from the held count.
    ch_en[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1 ch_en[1] = 1'b1;
    repeat (6) @(posedge clk);

    // Pending divisor 4 on ch1, then a sync restarts everything.
    #1 cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 27'd4;
    @(posedge clk); #1;
    cfg_we = 1'b0; sync = 1'b1;
    check("presync_pend1", 32'(pend[1]), 32'd1);
    @(posedge clk); #1;
    sync = 1'b0;
    check("sync_level", 32'(level), 32'd0);
    check("sync_pend", 32'(pend), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check("sync_tick1", 32'(tick[1]), 32'(k % 4 == 0));
    end

    // Asynchronous reset mid-period with a write pending.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 27'd7;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_pend", 32'(pend), 32'd0);
    check("arst_iter", 32'(iter_sig), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_sched(1'b0);

    // Randomised traffic, checked by the model through the monitor.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      ch_en[0] = ($urandom_range(0, 7) != 0);
      ch_en[1] = ($urandom_range(0, 7) != 0);
      sync     = ($urandom_range(0, 60) == 0);
      cfg_we   = ($urandom_range(0, 5) == 0);
      cfg_ch   = CHW'($urandom_range(0, 3));
      cfg_div  = CW'($urandom_range(0, 9));
    end
    @(posedge clk); #1;
    cfg_we = 1'b0; sync = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
